smbs_frame_ctrl: RTL and testbench

Sequencer for the serial bit-steering demultiplexer. It watches the serial line `serin` for a frame: start bit, 2-bit port number, 4 data bits and an optional parity bit. During the data phase it drives the demux lane select `PB` and bit select `LB` so that each data bit lands in `L<port>[bit]`. It also emits a per-bit load strobe and a frame-done pulse, so downstream lane registers can capture the steered bits. It sits between the serial receiver pin and the combinational demux, one instance per serial input.

---
 rtl/smbs_frame_ctrl.sv | 143 ++++++++++++++
 tb/tb_smbs_frame_ctrl.sv | 156 +++++++++++++++
 2 files changed

// File: rtl/smbs_frame_ctrl.sv
// Serial frame sequencer for the bit-steering demux: start, 2-bit port, 4 data bits LSB-first.
// Registered PB/LB/ld/done outputs; optional trailing even-parity bit when SMBS_PARITY_EN is defined.
module smbs_frame_ctrl #(
    parameter logic IDLE_LEVEL = 1'b1
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       en,
    input  logic       serin,
    output logic [3:0] PB,
    output logic [1:0] LB,
    output logic       ld,
    output logic       busy,
    output logic       done,
    output logic [1:0] port_id,
    output logic       err
);

    typedef enum logic [2:0] {
        S_IDLE,
        S_PORT,
        S_DATA,
`ifdef SMBS_PARITY_EN
        S_PAR,
`endif
        S_DONE
    } state_t;

    state_t     r_state;
    state_t     w_state_nxt;
    logic [1:0] r_cnt;
    logic [1:0] w_cnt_nxt;
    logic [1:0] r_port;
    logic [1:0] w_port_nxt;
    logic [3:0] r_pb;
    logic [1:0] r_lb;
    logic       r_ld;
    logic       r_busy;
    logic       r_done;
`ifdef SMBS_PARITY_EN
    logic       r_par;
    logic       w_par_nxt;
    logic       r_err;
`endif

    always_comb begin
        w_state_nxt = r_state;
        w_cnt_nxt   = r_cnt;
        w_port_nxt  = r_port;
`ifdef SMBS_PARITY_EN
        w_par_nxt   = r_par;
`endif
        case (r_state)
            S_IDLE: begin
                if (en && (serin == ~IDLE_LEVEL)) begin
                    w_state_nxt = S_PORT;
                    w_cnt_nxt   = 2'd0;
`ifdef SMBS_PARITY_EN
                    w_par_nxt   = 1'b0;
`endif
                end
            end
            S_PORT: begin
                w_port_nxt = {r_port[0], serin};
                if (r_cnt == 2'd1) begin
                    w_state_nxt = S_DATA;
                    w_cnt_nxt   = 2'd0;
                end else begin
                    w_cnt_nxt = r_cnt + 2'd1;
                end
            end
            S_DATA: begin
`ifdef SMBS_PARITY_EN
                w_par_nxt = r_par ^ serin;
`endif
                w_cnt_nxt = r_cnt + 2'd1;
                if (r_cnt == 2'd3) begin
`ifdef SMBS_PARITY_EN
                    w_state_nxt = S_PAR;
`else
                    w_state_nxt = S_DONE;
`endif
                end
            end
`ifdef SMBS_PARITY_EN
            S_PAR: begin
                w_par_nxt   = r_par ^ serin;
                w_state_nxt = S_DONE;
            end
`endif
            S_DONE: begin
                w_state_nxt = S_IDLE;
            end
            default: begin
                w_state_nxt = S_IDLE;
            end
        endcase
    end

    // Outputs are registered from the next state so they line up with the state they describe.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= S_IDLE;
            r_cnt   <= 2'd0;
            r_port  <= 2'd0;
            r_pb    <= 4'd0;
            r_lb    <= 2'd0;
            r_ld    <= 1'b0;
            r_busy  <= 1'b0;
            r_done  <= 1'b0;
`ifdef SMBS_PARITY_EN
            r_par   <= 1'b0;
            r_err   <= 1'b0;
`endif
        end else begin
            r_state <= w_state_nxt;
            r_cnt   <= w_cnt_nxt;
            r_port  <= w_port_nxt;
            r_pb    <= (w_state_nxt == S_DATA) ? (4'b0001 << w_port_nxt) : 4'd0;
            r_lb    <= (w_state_nxt == S_DATA) ? w_cnt_nxt : 2'd0;
            r_ld    <= (w_state_nxt == S_DATA);
            r_busy  <= (w_state_nxt != S_IDLE);
            r_done  <= (w_state_nxt == S_DONE);
`ifdef SMBS_PARITY_EN
            r_par   <= w_par_nxt;
            r_err   <= (w_state_nxt == S_DONE) && w_par_nxt;
`endif
        end
    end

    assign PB      = r_pb;
    assign LB      = r_lb;
    assign ld      = r_ld;
    assign busy    = r_busy;
    assign done    = r_done;
    assign port_id = r_port;
`ifdef SMBS_PARITY_EN
    assign err     = r_err;
`else
    assign err     = 1'b0;
`endif

endmodule

// File: tb/tb_smbs_frame_ctrl.sv
// Directed and randomized frames against a cycle-indexed frame model; lanes rebuilt from PB/LB/ld.
module tb_smbs_frame_ctrl;

    localparam logic IDLE = 1'b1;
`ifdef SMBS_PARITY_EN
    localparam int   FLEN   = 9;
    localparam bit   PAR_ON = 1'b1;
`else
    localparam int   FLEN   = 8;
    localparam bit   PAR_ON = 1'b0;
`endif

    logic       clk   = 1'b0;
    logic       rst_n = 1'b0;
    logic       en    = 1'b0;
    logic       serin = 1'b1;
    logic [3:0] PB;
    logic [1:0] LB;
    logic       ld;
    logic       busy;
    logic       done;
    logic [1:0] port_id;
    logic       err;

    smbs_frame_ctrl #(.IDLE_LEVEL(IDLE)) dut (
        .clk(clk), .rst_n(rst_n), .en(en), .serin(serin),
        .PB(PB), .LB(LB), .ld(ld), .busy(busy), .done(done),
        .port_id(port_id), .err(err)
    );

    always #5 clk = ~clk;

    int         tests = 0;
    int         fails = 0;
    logic [1:0] last_port = 2'd0;
    logic [3:0] lanes [4];
    wire  [11:0] obs = {PB, LB, ld, busy, done, err, port_id};

    // Downstream lane registers, loaded exactly as the demux would steer them.
    always @(posedge clk) begin
        if (ld) begin
            for (int i = 0; i < 4; i++)
                if (PB[i]) lanes[i][LB] <= serin;
        end
    end

    task automatic chk(input string tag, input logic [11:0] got, input logic [11:0] exp);
        tests++;
        assert (got === exp) else begin
            fails++;
            $error("FAIL %s got=%h exp=%h", tag, got, exp);
        end
    endtask

    // Expected outputs in the cycle following sample edge t_j of a frame.
    function automatic logic [11:0] model(input int j, input logic [1:0] p,
                                          input logic [3:0] d, input logic pbit);
        logic [3:0] e_pb;
        logic [1:0] e_lb;
        logic       e_ld, e_busy, e_done, e_err;
        e_pb = 4'd0; e_lb = 2'd0; e_ld = 1'b0; e_busy = 1'b0; e_done = 1'b0; e_err = 1'b0;
        if (j <= FLEN - 2) e_busy = 1'b1;
        if (j >= 2 && j <= 5) begin
            e_pb = 4'd1 << p;
            e_lb = 2'(j - 2);
            e_ld = 1'b1;
        end
        if (j == FLEN - 2) begin
            e_done = 1'b1;
            e_err  = PAR_ON ? ^{d, pbit} : 1'b0;
        end
        return {e_pb, e_lb, e_ld, e_busy, e_done, e_err, p};
    endfunction

    task automatic frame(input logic [1:0] p, input logic [3:0] d, input logic bad_par,
                         input logic drop_en, input int stop_j);
        logic       pbit;
        logic [11:0] mask;
        pbit = (^d) ^ bad_par;
        for (int j = 0; j < stop_j; j++) begin
            en = (drop_en && j >= 3) ? 1'b0 : 1'b1;
            if (j == 0)              serin = ~IDLE;
            else if (j == 1)         serin = p[1];
            else if (j == 2)         serin = p[0];
            else if (j <= 6)         serin = d[j-3];
            else if (j == 7 && PAR_ON) serin = pbit;
            else                     serin = 1'($urandom);
            @(posedge clk);
            @(negedge clk);
            // Port id is only defined once the data phase begins.
            mask = (j < 2) ? 12'hFFC : 12'hFFF;
            chk("frame", obs & mask, model(j, p, d, pbit) & mask);
        end
        if (stop_j >= FLEN) begin
            last_port = p;
            chk("lanes", {8'd0, lanes[p]}, {8'd0, d});
        end
    endtask

    task automatic idle(input int n, input logic s, input logic e);
        for (int i = 0; i < n; i++) begin
            serin = s;
            en    = e;
            @(posedge clk);
            @(negedge clk);
            chk("idle", obs, {10'd0, last_port});
        end
    endtask

    initial begin
        #100000;
        $display("FAIL timeout");
        $fatal(1, "timeout");
    end

    initial begin
        rst_n = 1'b0; serin = 1'b1; en = 1'b1;
        repeat (3) @(negedge clk);
        chk("reset", obs, 12'd0);
        rst_n = 1'b1;
        idle(20, 1'b1, 1'b1);

        frame(2'd2, 4'b1101, 1'b0, 1'b0, FLEN);
        idle(2, 1'b1, 1'b1);

        frame(2'd0, 4'($urandom), 1'b0, 1'b0, FLEN);
        frame(2'd3, 4'($urandom), 1'b0, 1'b0, FLEN);

        idle(10, ~IDLE, 1'b0);
        idle(1, 1'b1, 1'b1);
        frame(2'd1, 4'($urandom), 1'b0, 1'b1, FLEN);
        idle(2, 1'b1, 1'b1);

        frame(2'd3, 4'b0110, 1'b0, 1'b0, 5);
        #1 rst_n = 1'b0;
        #1 chk("rst_async", obs, 12'd0);
        #1 rst_n = 1'b1;
        last_port = 2'd0;
        idle(4, 1'b1, 1'b1);
        frame(2'd1, 4'b1010, 1'b0, 1'b0, FLEN);

        frame(2'd2, 4'b0011, 1'b0, 1'b0, FLEN);
        frame(2'd2, 4'b0011, 1'b1, 1'b0, FLEN);
        idle(1, 1'b1, 1'b1);

        for (int k = 0; k < 12; k++) begin
            frame(2'($urandom), 4'($urandom), 1'($urandom_range(0, 1)),
                  1'($urandom_range(0, 1)), FLEN);
            idle(int'($urandom_range(0, 2)), 1'b1, 1'b1);
        end

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
